riscv_lsu: RTL
==============

# riscv_lsu

Parametrised load/store unit for the multi-cycle RISC-V core. It replaces the fixed word-only data memory with a byte-addressed RAM that supports LB/LH/LW/LBU/LHU/SB/SH/SW, configurable wait states, selectable byte order, and fault reporting. It sits behind the core's memory stage. The core issues one request per LOAD/STORE instruction and holds its stage sequencer until `rsp_valid`.

## Interface
- `ADDR_WIDTH`, 12: byte-address bits implemented. RAM depth is 2**ADDR_WIDTH bytes.
- `WAIT_STATES`, 0: extra stall cycles inserted before each access (0..15).
- `BIG_ENDIAN`, 1: 1 means the lowest address holds the most significant byte (current core convention). 0 means little-endian.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request (high only in IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 of the instruction.
- `req_addr`  in  32  byte address (rs1 + imm).
- `req_wdata`  in  32  store data (rs2).
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  load result, extended to 32 bits. 0 for stores and faults.
- `rsp_fault`  out  1  request was misaligned, out of range, or had an illegal funct3.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Reset values:** FSM in IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_rdata`=0; `rsp_fault`=0; `busy`=0.
- RAM contents are not reset. The bench preloads them through the hierarchical array `mem[0..2**ADDR_WIDTH-1]` (8-bit entries).
- **FSM states:** IDLE, WAIT, ACCESS, RESP.
  - IDLE → WAIT on `req_valid` when WAIT_STATES>0; otherwise IDLE → ACCESS.
  - WAIT → ACCESS after WAIT_STATES cycles (4-bit down-counter).
  - ACCESS → RESP.
  - RESP → IDLE.
- **Request capture:** on acceptance (`req_valid && req_ready`), register we/funct3/addr/wdata. Inputs are ignored afterwards.
- **Fault conditions** are evaluated on captured values:
  - `addr[31:ADDR_WIDTH]` ≠ 0.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Load funct3 ∈ {3,6,7}.
  - Store funct3 ∈ {3..7}.
- A faulting request follows the same state sequence and latency. It writes nothing and returns `rsp_rdata`=0 with `rsp_fault`=1.
- **Stores:** the RAM is written at the ACCESS clock edge.
  - SB writes wdata[7:0] to `mem[a]`.
  - SH, big-endian: wdata[15:8] to `mem[a]` and wdata[7:0] to `mem[a+1]`. Swapped when BIG_ENDIAN=0.
  - SW writes all four bytes, ordered by BIG_ENDIAN.
- **Loads:** read at ACCESS, then aligned and extended into the `rsp_rdata` register.
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW returns the full word.

## Timing
- Acceptance to `rsp_valid` is WAIT_STATES+2 cycles.
  - Accept at edge N; ACCESS occupies cycle N+1+W; `rsp_valid` is high during cycle N+2+W.
- `rsp_valid`, `rsp_rdata` and `rsp_fault` are valid together for exactly one cycle.
- `rsp_rdata` and `rsp_fault` return to 0 the cycle after the pulse.
- No response backpressure. The core must sample `rsp_valid` when it is high.
- `req_ready` deasserts the cycle after acceptance and reasserts the cycle after RESP.
  - Minimum request spacing is WAIT_STATES+3 cycles.
- A request held during `busy` is not accepted until `req_ready` is high again.
- **Reset mid-operation:** asynchronous return to IDLE with outputs at reset values.
  - A store before its ACCESS edge is dropped.
  - A store whose ACCESS edge has completed remains in RAM.
- Load-after-store to the same address returns the new data, since accesses are strictly sequential.

## Structure
- Shared defines header (with the existing `LOAD`/`STORE`/`LW`/`SW` macros) gains:
  - funct3 constants `LB`=0, `LH`=1, `LBU`=4, `LHU`=5, `SB`=0, `SH`=1.
  - FSM state encodings, one-hot, matching the core's stage style.
- Sub-module `riscv_lsu_align`: combinational lane steering, covering store byte enables and data placement, plus load extraction and extension. It is parametrised by BIG_ENDIAN and unit-testable alone.
- `riscv_lsu` holds the FSM, wait counter, request registers and RAM array.

## Test plan
1. **Reset and store/load round trip:** reset; SW 0x0001F000 @0x000, then LW @0x000 → `rsp_rdata`=0x0001F000, `mem[0..3]`=00,01,F0,00 (BIG_ENDIAN=1).
2. **Byte/halfword extension:** preload `mem[4..7]`=80,FF,12,34. Expected results:
   - LB @4 → 0xFFFFFF80.
   - LBU @4 → 0x00000080.
   - LH @6 → 0x00001234.
   - LHU @4 → 0x000080FF.
3. **Wait states:** WAIT_STATES=3; `rsp_valid` exactly 5 cycles after acceptance; `req_ready` low for 5 cycles.
4. **Faults:**
   - LW @0x002 → `rsp_fault`=1, `rsp_rdata`=0.
   - SH @0x001 → fault, `mem[1..2]` unchanged.
   - LW @0x1000 (ADDR_WIDTH=12) → fault.
   - Load funct3=3 → fault.
5. **Little-endian:** BIG_ENDIAN=0; SH 0xABCD @0x010 → `mem[0x10]`=CD, `mem[0x11]`=AB; LH @0x010 → 0xFFFFABCD.
6. **Reset mid-store:** WAIT_STATES=2; SW 0xDEADBEEF @0x20; assert `rst_n` low during WAIT → RAM unchanged, outputs at reset values, next request accepted normally.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared definitions for the load/store unit.
//   - funct3 encodings for the supported loads and stores
//   - one-hot FSM state encoding
//   - lane_t: four byte lanes, lane i = byte at word offset i
//   - funct3_illegal(): unsupported funct3 for a load or a store
package riscv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_WAIT   = 4'b0010,
    ST_ACCESS = 4'b0100,
    ST_RESP   = 4'b1000
  } lsu_state_e;

  typedef logic [3:0][7:0] lane_t;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > 3'd2);
    return (f3 == 3'd3) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: combinational byte-lane steering.
//   funct3  : access type (size in [1:0], unsigned flag in [2])
//   offset  : byte offset of the access within its word
//   wdata   : store data (value in the low bits)
//   rlanes  : the four bytes of the addressed word, as read from RAM
//   wbe     : per-lane write enables for a store
//   wlanes  : per-lane write data for a store
//   rdata   : load value, aligned and sign/zero extended
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  lane_t       rlanes,
  output logic [3:0]  wbe,
  output lane_t       wlanes,
  output logic [31:0] rdata
);

  // Bytes destined for the lower (even) and upper (odd) address of a halfword
  logic [7:0]  half_even, half_odd;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_w;

  always_comb begin
    half_even = BIG_ENDIAN ? wdata[15:8] : wdata[7:0];
    half_odd  = BIG_ENDIAN ? wdata[7:0]  : wdata[15:8];
    wbe       = 4'b0000;
    wlanes    = '0;
    unique case (funct3[1:0])
      2'b00: begin
        wbe    = 4'b0001 << offset;
        wlanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        // Lanes 0/1 and 2/3 both carry the halfword; the enables pick one pair
        wbe    = offset[1] ? 4'b1100 : 4'b0011;
        wlanes = {half_odd, half_even, half_odd, half_even};
      end
      default: begin
        wbe = 4'b1111;
        if (BIG_ENDIAN) wlanes = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
        else            wlanes = wdata;
      end
    endcase
  end

  always_comb begin
    ld_b = rlanes[offset];
    if (BIG_ENDIAN) begin
      ld_h = {rlanes[{offset[1], 1'b0}], rlanes[{offset[1], 1'b1}]};
      ld_w = {rlanes[0], rlanes[1], rlanes[2], rlanes[3]};
    end else begin
      ld_h = {rlanes[{offset[1], 1'b1}], rlanes[{offset[1], 1'b0}]};
      ld_w = rlanes;
    end
    unique case (funct3)
      3'd0:    rdata = {{24{ld_b[7]}}, ld_b};
      3'd1:    rdata = {{16{ld_h[15]}}, ld_h};
      3'd2:    rdata = ld_w;
      3'd4:    rdata = {24'd0, ld_b};
      3'd5:    rdata = {16'd0, ld_h};
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: byte-addressed load/store unit with optional wait states.
//   clk, rst_n               : clock, asynchronous active-low reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_we/funct3/addr/wdata : request fields, captured on acceptance
//   rsp_valid/rdata/fault    : one-cycle registered response
//   busy                     : high whenever the FSM is not in IDLE
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        busy
);

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  logic [7:0] mem [0:DEPTH-1];

  lsu_state_e  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;

  logic        fault;
  lane_t       rd_lanes, wr_lanes;
  logic [3:0]  wr_be;
  logic [31:0] ld_data;
  logic [ADDR_WIDTH-3:0] word_idx;

  assign word_idx = addr_q[ADDR_WIDTH-1:2];

  // Shift form also covers ADDR_WIDTH=32, where no upper bits exist
  assign fault = ((addr_q >> ADDR_WIDTH) != 32'd0)
              || (funct3_q[1:0] == 2'b01 && addr_q[0])
              || (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00)
              || funct3_illegal(we_q, funct3_q);

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign rd_lanes[gi] = mem[{word_idx, 2'(gi)}];
  end

  riscv_lsu_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .funct3 (funct3_q),
    .offset (addr_q[1:0]),
    .wdata  (wdata_q),
    .rlanes (rd_lanes),
    .wbe    (wr_be),
    .wlanes (wr_lanes),
    .rdata  (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_fault_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) state_d = ST_ACCESS;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_fault_d = fault;
        rsp_rdata_d = (fault || we_q) ? 32'd0 : ld_data;
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = !req_ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_fault_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // RAM is not reset; a store commits only on its ACCESS edge
  always_ff @(posedge clk) begin
    if (state_q == ST_ACCESS && we_q && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[{word_idx, 2'(i)}] <= wr_lanes[i];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule
